// File: rtl/hqm_aw_rf_pkg.sv
// hqm_aw_rf_pkg: shared types and constants for the 2048x14 RF read stage.
package hqm_aw_rf_pkg;
    typedef logic [10:0] rf2048x14_addr_t;
    typedef logic [13:0] rf2048x14_data_t;
    localparam int RF_RD_LAT = 1;
endpackage

// File: rtl/hqm_aw_rf_rd_fifo.sv
// hqm_aw_rf_rd_fifo: DEPTH x DW flop FIFO with explicit pointer wrap for any DEPTH.
module hqm_aw_rf_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW = 14,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          rclk,
    input  logic          rclk_rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign rd    = pop & ~empty;
    // a full FIFO still takes a write when a slot frees in the same cycle
    assign wr    = push & (~full | rd);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge rclk or negedge rclk_rst_n) begin
        if (!rclk_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= inc(wr_ptr);
            end
            if (rd) rd_ptr <= inc(rd_ptr);
            cnt <= cnt + CW'(wr) - CW'(rd);
        end
    end
endmodule

// File: rtl/hqm_aw_rf_rd_stage_2048x14.sv
// hqm_aw_rf_rd_stage_2048x14: credit-protected read stage for the power-gated 2048x14 RF.
module hqm_aw_rf_rd_stage_2048x14
    import hqm_aw_rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = $bits(rf2048x14_addr_t),
    parameter int DW = $bits(rf2048x14_data_t),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          rclk,
    input  logic          rclk_rst_n,
    input  logic          req_v,
    input  logic [AW-1:0] req_addr,
    output logic          req_ready,
    output logic          rf_re,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    input  logic          rf_isol,
    input  logic          rf_pwr_off,
    output logic          out_v,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] fifo_cnt,
    output logic          idle,
    output logic          err_ovf
);
    logic          rd_pend, fifo_full, fifo_empty, pop;
    logic [CW:0]   inflight;

    // in-flight read holds a credit until its data lands in the FIFO
    assign inflight  = {1'b0, fifo_cnt} + (CW + 1)'(rd_pend);
    assign req_ready = rclk_rst_n & ~rf_isol & ~rf_pwr_off & (inflight < (CW + 1)'(DEPTH));
    assign rf_re     = req_v & req_ready;
    assign rf_raddr  = rclk_rst_n ? req_addr : '0;
    assign out_v     = ~fifo_empty;
    assign pop       = out_v & out_ready;
    assign idle      = ~rd_pend & fifo_empty;

    always_ff @(posedge rclk or negedge rclk_rst_n) begin
        if (!rclk_rst_n) begin
            rd_pend <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            rd_pend <= rf_re;
            err_ovf <= err_ovf | (rd_pend & fifo_full & ~pop);
        end
    end

    hqm_aw_rf_rd_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .rclk       (rclk),
        .rclk_rst_n (rclk_rst_n),
        .push       (rd_pend),
        .wdata      (rf_rdata),
        .pop        (pop),
        .rdata      (out_data),
        .cnt        (fifo_cnt),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );
endmodule

// File: tb/tb_hqm_aw_rf_rd_stage_2048x14.sv
// tb_hqm_aw_rf_rd_stage_2048x14: table-driven and directed checks of the RF read stage.
module tb_hqm_aw_rf_rd_stage_2048x14;
    logic        rclk = 0, rclk_rst_n = 0;
    logic        req_v = 0, rf_isol = 0, rf_pwr_off = 0, out_ready = 0;
    logic [10:0] req_addr = 0, rf_raddr;
    logic [13:0] rf_rdata = 0, out_data;
    logic        req_ready, rf_re, out_v, idle, err_ovf;
    logic [2:0]  fifo_cnt;
    int          n_chk = 0, n_fail = 0;
    logic [13:0] q[$];

    hqm_aw_rf_rd_stage_2048x14 dut (
        .rclk(rclk), .rclk_rst_n(rclk_rst_n), .req_v(req_v), .req_addr(req_addr),
        .req_ready(req_ready), .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_isol(rf_isol), .rf_pwr_off(rf_pwr_off), .out_v(out_v), .out_data(out_data),
        .out_ready(out_ready), .fifo_cnt(fifo_cnt), .idle(idle), .err_ovf(err_ovf)
    );

    always #5 rclk = ~rclk;

    function automatic logic [13:0] f(input logic [10:0] a);
        return 14'h2DA5 ^ {3'b0, a};
    endfunction

    // RF model: data one cycle after re, garbage otherwise
    always @(posedge rclk) rf_rdata <= rf_re ? f(rf_raddr) : 14'h3FFF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_tick();
        if (rf_re) q.push_back(f(req_addr));
        if (out_v && out_ready) begin
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sb_data", {18'b0, out_data}, {18'b0, q.pop_front()});
        end
    endtask

    task automatic drive(input logic v, input logic [10:0] a, input logic ordy);
        @(posedge rclk);
        #1;
        req_v = v;
        req_addr = a;
        out_ready = ordy;
        #1;
    endtask

    typedef struct {
        logic v; logic [10:0] a; logic iso, pwr, ordy;
        logic e_rdy, e_re, e_ov; logic [13:0] e_d; logic [2:0] e_cnt; logic e_idle;
    } vec_t;
    vec_t tbl[23];

    function automatic vec_t mk(logic v, logic [10:0] a, logic iso, logic pwr, logic ordy,
                                logic rdy, logic re, logic ov, logic [13:0] d, logic [2:0] c, logic id);
        vec_t t;
        t.v = v; t.a = a; t.iso = iso; t.pwr = pwr; t.ordy = ordy;
        t.e_rdy = rdy; t.e_re = re; t.e_ov = ov; t.e_d = d; t.e_cnt = c; t.e_idle = id;
        return t;
    endfunction

    initial begin
        int n_re, issued;
        tbl[0]  = mk(1, 11'h7FF, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 1, 0, 1, f(11'h7FF), 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, 11'h010, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        tbl[5]  = mk(1, 11'h011, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[6]  = mk(1, 11'h012, 0, 0, 0, 1, 1, 1, f(11'h010), 1, 0);
        tbl[7]  = mk(1, 11'h013, 0, 0, 0, 1, 1, 1, f(11'h010), 2, 0);
        tbl[8]  = mk(1, 11'h014, 0, 0, 0, 0, 0, 1, f(11'h010), 3, 0);
        tbl[9]  = mk(1, 11'h014, 0, 0, 0, 0, 0, 1, f(11'h010), 4, 0);
        tbl[10] = mk(1, 11'h014, 0, 0, 0, 0, 0, 1, f(11'h010), 4, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 1, f(11'h010), 4, 0);
        tbl[12] = mk(0, 0, 0, 0, 1, 1, 0, 1, f(11'h011), 3, 0);
        tbl[13] = mk(0, 0, 0, 0, 1, 1, 0, 1, f(11'h012), 2, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 1, 0, 1, f(11'h013), 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        tbl[16] = mk(1, 11'h020, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        tbl[17] = mk(1, 11'h021, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 11'h021, 1, 0, 1, 0, 0, 1, f(11'h020), 1, 0);
        tbl[19] = mk(1, 11'h022, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        tbl[20] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 0, 1, 1, 0, 0, 1, f(11'h022), 1, 0);
        tbl[22] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);

        repeat (3) @(posedge rclk);
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rf_re", rf_re, 0);
        chk("rst_raddr", rf_raddr, 0);
        chk("rst_out_v", out_v, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err_ovf, 0);
        @(posedge rclk);
        #1 rclk_rst_n = 1;

        // single read, back-pressure, isolation and power-off
        for (int k = 0; k < 23; k++) begin
            @(posedge rclk);
            #1;
            req_v = tbl[k].v; req_addr = tbl[k].a; rf_isol = tbl[k].iso;
            rf_pwr_off = tbl[k].pwr; out_ready = tbl[k].ordy;
            #1;
            chk($sformatf("v%0d_req_ready", k), req_ready, tbl[k].e_rdy);
            chk($sformatf("v%0d_rf_re", k), rf_re, tbl[k].e_re);
            if (tbl[k].e_re) chk($sformatf("v%0d_raddr", k), rf_raddr, tbl[k].a);
            chk($sformatf("v%0d_out_v", k), out_v, tbl[k].e_ov);
            if (tbl[k].e_ov) chk($sformatf("v%0d_out_data", k), out_data, tbl[k].e_d);
            chk($sformatf("v%0d_cnt", k), fifo_cnt, tbl[k].e_cnt);
            chk($sformatf("v%0d_idle", k), idle, tbl[k].e_idle);
        end
        chk("bp_err_ovf", err_ovf, 0);

        // streaming across 0x3FF -> 0x400
        n_re = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1, 11'h3D0 + 11'(i), 1);
            chk("st_ready", req_ready, 1);
            if (fifo_cnt > 1) chk("st_cnt_le1", fifo_cnt, 1);
            n_re += int'(rf_re);
            sb_tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1);
            sb_tick();
        end
        chk("st_re_count", n_re, 100);
        chk("st_sb_empty", q.size(), 0);
        chk("st_idle", idle, 1);

        // fill to DEPTH, then pop with a read in flight
        issued = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 11'h100 + 11'(issued), 0);
            sb_tick();
            issued += int'(rf_re);
        end
        chk("full_issued", issued, 4);
        drive(1, 11'h104, 1);
        chk("full_cnt", fifo_cnt, 4);
        chk("full_ready", req_ready, 0);
        sb_tick();
        drive(1, 11'h104, 0);
        chk("refill_cnt", fifo_cnt, 3);
        chk("refill_re", rf_re, 1);
        sb_tick();
        drive(0, 0, 1);
        chk("pushpop_pre_cnt", fifo_cnt, 3);
        chk("pushpop_pend", idle, 0);
        sb_tick();
        drive(0, 0, 1);
        chk("pushpop_cnt", fifo_cnt, 3);
        sb_tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1);
            sb_tick();
        end
        chk("wrap_sb_empty", q.size(), 0);
        chk("wrap_cnt", fifo_cnt, 0);
        chk("wrap_err_ovf", err_ovf, 0);

        // reset with fifo_cnt=3 and a read in flight
        for (int i = 0; i < 4; i++) drive(1, 11'h200 + 11'(i), 0);
        drive(1, 11'h204, 0);
        chk("prerst_cnt", fifo_cnt, 3);
        chk("prerst_idle", idle, 0);
        rclk_rst_n = 0;
        #1;
        chk("mrst_req_ready", req_ready, 0);
        chk("mrst_rf_re", rf_re, 0);
        chk("mrst_raddr", rf_raddr, 0);
        chk("mrst_out_v", out_v, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_cnt", fifo_cnt, 0);
        chk("mrst_idle", idle, 1);
        chk("mrst_err", err_ovf, 0);
        req_v = 0;
        q.delete();
        @(posedge rclk);
        #1 rclk_rst_n = 1;
        drive(1, 11'h7FF, 1);
        chk("post_re", rf_re, 1);
        chk("post_raddr", rf_raddr, 11'h7FF);
        drive(0, 0, 1);
        chk("post_n1_out_v", out_v, 0);
        drive(0, 0, 1);
        chk("post_n2_out_v", out_v, 1);
        chk("post_n2_data", out_data, 14'h2A5A);
        drive(0, 0, 1);
        chk("post_idle", idle, 1);
        chk("post_cnt", fifo_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
